dmem_responder: RTL
===================

Name: dmem_responder

Overview:
- Multi-cycle data-memory responder: the memory-side end of the processor's data-memory interface (addr, write_enable, byte/half-word/sign-extend controls, data in/out).
- Adds a request/ready handshake and a configurable access latency, so the processor can be exercised against wait-stated memory.
- Storage is big-endian, byte-addressed and SIZE bytes deep. Bit 0 is the MSB on every bus.
- It sits between the processor's data port and the bench, in place of a zero-latency memory.

Parameters:
- SIZE, 16384: storage depth in bytes (power of two).
- LATENCY, 2: number of wait cycles between request acceptance and the response (0..15).

Ports:
- clock  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low; port name as used throughout the codebase.
- req_valid  in  1  request present; sampled only in IDLE.
- addr  in  [0:31]  byte address.
- write_enable  in  1  1 = store, 0 = load.
- mem_byte  in  1  byte access.
- mem_half_word  in  1  half-word access (ignored if mem_byte=1).
- sign_extend  in  1  loads: 1 = sign-extend, 0 = zero-extend.
- data_in  in  [0:31]  store data, right-justified.
- data_out  out  [0:31]  load data, right-justified; valid while ready=1.
- ready  out  1  one-cycle response strobe.
- error  out  1  qualifies ready; request was misaligned or out of range.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE; ready=0, error=0, data_out=0, latency counter=0.
  - The storage array is NOT cleared.
  - Reset mid-operation abandons the request: a pending store is dropped and memory is unchanged.
- FSM states are IDLE, WAIT and RESP.
  - IDLE: on an edge with req_valid=1, latch addr, data_in and all controls; load cnt=LATENCY; go to WAIT. Call this the accepting edge t0.
  - WAIT: if cnt==0, go to RESP; otherwise decrement cnt.
  - RESP: ready=1 for exactly one cycle, then go to IDLE.
  - ready and error are registered: high for exactly the cycle after edge t0+LATENCY+1.
- req_valid outside IDLE is ignored, not queued. The minimum spacing between accepted requests is LATENCY+3 edges.
- Access size: byte if mem_byte; else half-word if mem_half_word; else word.
- Error conditions (checked on the latched request):
  - half-word with addr[31]=1;
  - word with addr[30:31]!=0;
  - any addr+size-1 >= SIZE.
  - On error: ready=1, error=1, data_out=0, no store performed.
- Store:
  - Committed on the edge entering RESP.
  - Byte stores data_in[24:31] at addr.
  - Half-word stores data_in[16:23] at addr and data_in[24:31] at addr+1.
  - Word stores data_in[0:7] at addr through data_in[24:31] at addr+3.
  - data_out=0 during a store response.
- Load:
  - Read on the edge entering RESP.
  - Byte/half-word results are placed in the low bits; upper bits are copies of the MSB if sign_extend=1, else 0.
  - Word loads ignore sign_extend.
- data_out holds its value until the next response or reset.
- Addresses above SIZE are not wrapped; they raise error.

Decomposition:
- Shared header dmem_defs.vh holds:
  - FSM state encodings (IDLE=2'd0, WAIT=2'd1, RESP=2'd2);
  - access-size codes (SZ_BYTE, SZ_HALF, SZ_WORD);
  - the LATENCY counter width (4).
- Sub-module dmem_byte_array holds the byte storage.
  - SIZE-deep 8-bit mem.
  - Four byte read ports and four write ports with per-byte enables.
  - Keeps the array hierarchically accessible for bench preload/dump.

Test Plan:
- LATENCY=2; store word 0x12345678 at 0x2000, accepted at edge t0 -> ready=1, error=0 only during the cycle after edge t0+3; then mem[0x2000..0x2003]=12,34,56,78.
- Byte load 0x2001, sign_extend=1 -> data_out=0x00000034. Half-word load 0x2002 -> 0x00005678.
- Store byte 0x80 at 0x2004, then byte load with sign_extend=1 -> 0xFFFFFF80; with sign_extend=0 -> 0x00000080.
- Word load at 0x2002, and half-word load at 0x2001 -> ready=1, error=1, data_out=0; a misaligned store at 0x2002 leaves memory unchanged.
- Drive reset low two cycles after accepting a store to 0x2008 -> ready never asserts, mem[0x2008..0x200B] unchanged, all outputs 0.
- LATENCY=0; back-to-back requests with req_valid held high -> ready every 3rd cycle; requests arriving during WAIT/RESP are not serviced.

Source files
------------

// File: rtl/dmem_responder_pkg.sv
// Shared types for the data-memory responder: FSM states, access sizes, latency counter width.
package dmem_responder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_e;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'd0,
      SZ_HALF = 2'd1,
      SZ_WORD = 2'd2
   } size_e;

   localparam int unsigned CNT_W = 4;

   function automatic logic [2:0] size_bytes(input size_e sz);
      case (sz)
         SZ_BYTE: size_bytes = 3'd1;
         SZ_HALF: size_bytes = 3'd2;
         default: size_bytes = 3'd4;
      endcase
   endfunction

endpackage

// File: rtl/dmem_byte_array.sv
// Byte-wide storage with four combinational read lanes and four enabled write lanes.
// The array is never reset; the bench reaches it as u_array.mem.
module dmem_byte_array #(
   parameter int unsigned SIZE = 16384,
   parameter int unsigned AW   = $clog2(SIZE)
) (
   input  logic          clk_i,
   input  logic [AW-1:0] rd_addr_i [4],
   output logic [7:0]    rd_data_o [4],
   input  logic [3:0]    wr_en_i,
   input  logic [AW-1:0] wr_addr_i [4],
   input  logic [7:0]    wr_data_i [4]
);

   logic [7:0] mem [SIZE];

   always_comb begin
      for (int unsigned k = 0; k < 4; k++) begin
         rd_data_o[k] = mem[rd_addr_i[k]];
      end
   end

   always_ff @(posedge clk_i) begin
      for (int unsigned k = 0; k < 4; k++) begin
         if (wr_en_i[k]) begin
            mem[wr_addr_i[k]] <= wr_data_i[k];
         end
      end
   end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle big-endian data-memory responder with request/ready handshake and fixed wait states.
// Bit 0 is the MSB on every bus; byte lane 0 is the byte at the request address.
module dmem_responder
   import dmem_responder_pkg::*;
#(
   parameter int unsigned SIZE    = 16384,
   parameter int unsigned LATENCY = 2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        req_valid,
   input  logic [0:31] addr,
   input  logic        write_enable,
   input  logic        mem_byte,
   input  logic        mem_half_word,
   input  logic        sign_extend,
   input  logic [0:31] data_in,
   output logic [0:31] data_out,
   output logic        ready,
   output logic        error
);

   localparam int unsigned AW = $clog2(SIZE);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [0:31]      addr_q, addr_d, data_q, data_d, dout_q, dout_d;
   logic             we_q, we_d, sext_q, sext_d;
   logic             ready_q, ready_d, error_q, error_d;
   size_e            size_q, size_d;

   logic [31:0]   base, st_word, ld_word;
   logic [AW-1:0] lane_addr [4];
   logic [7:0]    rd_data [4];
   logic [7:0]    wr_data [4];
   logic [3:0]    lane_mask, wr_en;
   logic          misalign, range_err, req_err, fill;

   assign base    = addr_q;
   assign st_word = data_q;

   always_comb begin
      for (int unsigned k = 0; k < 4; k++) begin
         lane_addr[k] = base[AW-1:0] + AW'(k);
      end
   end

   always_comb begin
      fill       = sext_q & rd_data[0][7];
      misalign   = 1'b0;
      lane_mask  = 4'b1111;
      ld_word    = {rd_data[0], rd_data[1], rd_data[2], rd_data[3]};
      wr_data[0] = st_word[31:24];
      wr_data[1] = st_word[23:16];
      wr_data[2] = st_word[15:8];
      wr_data[3] = st_word[7:0];
      case (size_q)
         SZ_BYTE: begin
            lane_mask  = 4'b0001;
            wr_data[0] = st_word[7:0];
            ld_word    = {{24{fill}}, rd_data[0]};
         end
         SZ_HALF: begin
            misalign   = base[0];
            lane_mask  = 4'b0011;
            wr_data[0] = st_word[15:8];
            wr_data[1] = st_word[7:0];
            ld_word    = {{16{fill}}, rd_data[0], rd_data[1]};
         end
         default: begin
            misalign = |base[1:0];
         end
      endcase
      // addr+size-1 >= SIZE rewritten as addr+size > SIZE, in 33 bits so it cannot wrap
      range_err = ({1'b0, base} + {30'b0, size_bytes(size_q)}) > 33'(SIZE);
      req_err   = misalign | range_err;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      data_d  = data_q;
      we_d    = we_q;
      size_d  = size_q;
      sext_d  = sext_q;
      ready_d = 1'b0;
      error_d = 1'b0;
      dout_d  = dout_q;
      wr_en   = '0;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               addr_d  = addr;
               data_d  = data_in;
               we_d    = write_enable;
               sext_d  = sign_extend;
               size_d  = mem_byte ? SZ_BYTE : (mem_half_word ? SZ_HALF : SZ_WORD);
               cnt_d   = CNT_W'(LATENCY);
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (cnt_q == '0) begin
               state_d = RESP;
               ready_d = 1'b1;
               error_d = req_err;
               dout_d  = (req_err || we_q) ? '0 : ld_word;
               if (we_q && !req_err) begin
                  wr_en = lane_mask;
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         data_q  <= '0;
         we_q    <= 1'b0;
         size_q  <= SZ_BYTE;
         sext_q  <= 1'b0;
         ready_q <= 1'b0;
         error_q <= 1'b0;
         dout_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         we_q    <= we_d;
         size_q  <= size_d;
         sext_q  <= sext_d;
         ready_q <= ready_d;
         error_q <= error_d;
         dout_q  <= dout_d;
      end
   end

   assign data_out = dout_q;
   assign ready    = ready_q;
   assign error    = error_q;

   dmem_byte_array #(
      .SIZE (SIZE),
      .AW   (AW)
   ) u_array (
      .clk_i     (clock),
      .rd_addr_i (lane_addr),
      .rd_data_o (rd_data),
      .wr_en_i   (wr_en),
      .wr_addr_i (lane_addr),
      .wr_data_i (wr_data)
   );

endmodule
